// File: rtl/ac_compressor_sequencer_pkg.sv
// Shared state encodings and timing defaults for the AC compressor sequencer.
// Imported by the RTL and by the bench so both agree on encodings.
package ac_compressor_sequencer_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FAN_LEAD = 3'd1;
    localparam logic [2:0] RUN      = 3'd2;
    localparam logic [2:0] FAN_TAIL = 3'd3;
    localparam logic [2:0] LOCKOUT  = 3'd4;
    localparam logic [2:0] FAULT    = 3'd5;

    localparam int DEF_CNT_W           = 8;
    localparam int DEF_FAN_LEAD_CYCLES = 4;
    localparam int DEF_MIN_ON_CYCLES   = 16;
    localparam int DEF_FAN_TAIL_CYCLES = 8;
    localparam int DEF_MIN_OFF_CYCLES  = 32;

endpackage

// File: rtl/ac_down_counter.sv
// Loadable down-counter that saturates at zero; shared by all timed states.
// Load wins over decrement.
module ac_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ac_compressor_sequencer.sv
// Fan/compressor sequencer: fan lead and tail, minimum on-time,
// anti-short-cycle lockout and fault override.
module ac_compressor_sequencer
    import ac_compressor_sequencer_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int FAN_LEAD_CYCLES = DEF_FAN_LEAD_CYCLES,
    parameter int MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
    parameter int FAN_TAIL_CYCLES = DEF_FAN_TAIL_CYCLES,
    parameter int MIN_OFF_CYCLES  = DEF_MIN_OFF_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ac_req,
    input  logic       fault,
    output logic       fan_on,
    output logic       comp_on,
    output logic       lockout,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(FAN_LEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(FAN_TAIL_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(MIN_OFF_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic             ran_flag;
    logic             set_ran;
    logic             clr_ran;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             zero;
    logic             fan_d;
    logic             comp_d;
    logic             lock_d;

    ac_down_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (!load),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ran_flag <= 1'b0;
            fan_on   <= 1'b0;
            comp_on  <= 1'b0;
            lockout  <= 1'b0;
        end else begin
            state   <= next_state;
            fan_on  <= fan_d;
            comp_on <= comp_d;
            lockout <= lock_d;
            if (clr_ran) begin
                ran_flag <= 1'b0;
            end else if (set_ran) begin
                ran_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        set_ran    = 1'b0;
        clr_ran    = 1'b0;
        if (fault) begin
            next_state = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (ac_req) begin
                        next_state = FAN_LEAD;
                        load       = 1'b1;
                        load_val   = LEAD_LD;
                    end
                end
                FAN_LEAD: begin
                    if (!ac_req) begin
                        next_state = FAN_TAIL;
                        load       = 1'b1;
                        load_val   = TAIL_LD;
                    end else if (zero) begin
                        next_state = RUN;
                        load       = 1'b1;
                        load_val   = ON_LD;
                        set_ran    = 1'b1;
                    end
                end
                RUN: begin
                    if (zero && !ac_req) begin
                        next_state = FAN_TAIL;
                        load       = 1'b1;
                        load_val   = TAIL_LD;
                    end
                end
                FAN_TAIL: begin
                    if (zero) begin
                        if (ran_flag) begin
                            next_state = LOCKOUT;
                            load       = 1'b1;
                            load_val   = OFF_LD;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (zero) begin
                        next_state = IDLE;
                        clr_ran    = 1'b1;
                    end
                end
                FAULT: begin
                    next_state = LOCKOUT;
                    load       = 1'b1;
                    load_val   = OFF_LD;
                end
                default: begin
                    next_state = IDLE;
                    clr_ran    = 1'b1;
                end
            endcase
        end
    end

    // Outputs are the decode of the state being entered, so they flip with it.
    always_comb begin
        fan_d  = 1'b0;
        comp_d = 1'b0;
        lock_d = 1'b0;
        case (next_state)
            FAN_LEAD: fan_d = 1'b1;
            RUN: begin
                fan_d  = 1'b1;
                comp_d = 1'b1;
            end
            FAN_TAIL: fan_d = 1'b1;
            LOCKOUT:  lock_d = 1'b1;
            FAULT:    lock_d = 1'b1;
            default: begin
                fan_d  = 1'b0;
                comp_d = 1'b0;
                lock_d = 1'b0;
            end
        endcase
    end

    assign seq_state = state;

endmodule

// File: tb/tb_ac_compressor_sequencer.sv
// Directed bench: expected outputs per edge queued up front, popped and
// compared as the simulation reaches each edge.
module tb_ac_compressor_sequencer;
    import ac_compressor_sequencer_pkg::*;

    logic       clk;
    logic       reset;
    logic       ac_req;
    logic       fault;
    logic       fan_on;
    logic       comp_on;
    logic       lockout;
    logic [2:0] seq_state;

    typedef struct {
        int         e;
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   ecnt;
    int   total;
    int   bad;

    ac_compressor_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .ac_req    (ac_req),
        .fault     (fault),
        .fan_on    (fan_on),
        .comp_on   (comp_on),
        .lockout   (lockout),
        .seq_state (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fan, comp, lockout, state
    function automatic void push(input int e, input logic f, input logic c,
                                 input logic l, input logic [2:0] s,
                                 input string tag);
        exp_t x;
        x.e   = e;
        x.v   = {f, c, l, s};
        x.tag = tag;
        sb.push_back(x);
    endfunction

    task automatic step();
        exp_t       x;
        logic [5:0] obs;
        @(posedge clk);
        #1;
        ecnt++;
        while (sb.size() != 0 && sb[0].e <= ecnt) begin
            x   = sb.pop_front();
            obs = {fan_on, comp_on, lockout, seq_state};
            total++;
            assert (x.e == ecnt && obs === x.v) else begin
                bad++;
                $error("FAIL %s edge=%0d observed=%b expected=%b (due edge %0d)",
                       x.tag, ecnt, obs, x.v, x.e);
            end
        end
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) step();
    endtask

    task automatic reset_dut();
        reset  = 1'b1;
        ac_req = 1'b0;
        fault  = 1'b0;
        ecnt   = -1000;
        step();
        step();
        reset = 1'b0;
        ecnt  = -1;
    endtask

    task automatic drain_check(input string tag);
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL %s leftover observed=%0d expected=0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ecnt  = -1000;
        reset  = 1'b1;
        ac_req = 1'b0;
        fault  = 1'b0;

        // Start and hold
        reset_dut();
        push(0,  0, 0, 0, IDLE,     "reset_idle");
        push(1,  1, 0, 0, FAN_LEAD, "start_fan");
        push(4,  1, 0, 0, FAN_LEAD, "start_lead_end");
        push(5,  1, 1, 0, RUN,      "start_comp");
        push(40, 1, 1, 0, RUN,      "start_hold");
        run_to(0);
        ac_req = 1'b1;
        run_to(40);
        drain_check("start");

        // Abort during fan lead
        reset_dut();
        push(1,  1, 0, 0, FAN_LEAD, "abort_lead");
        push(2,  1, 0, 0, FAN_TAIL, "abort_tail");
        push(9,  1, 0, 0, FAN_TAIL, "abort_tail_end");
        push(10, 0, 0, 0, IDLE,     "abort_idle");
        push(12, 0, 0, 0, IDLE,     "abort_no_lock");
        run_to(0);
        ac_req = 1'b1;
        run_to(1);
        ac_req = 1'b0;
        run_to(12);
        drain_check("abort");

        // Minimum on-time, tail, lockout and held re-request
        reset_dut();
        push(6,  1, 1, 0, RUN,      "minon_run");
        push(20, 1, 1, 0, RUN,      "minon_hold");
        push(21, 1, 0, 0, FAN_TAIL, "minon_drop");
        push(28, 1, 0, 0, FAN_TAIL, "tail_end");
        push(29, 0, 0, 1, LOCKOUT,  "lock_start");
        push(40, 0, 0, 1, LOCKOUT,  "lock_ignore_req");
        push(60, 0, 0, 1, LOCKOUT,  "lock_end");
        push(61, 0, 0, 0, IDLE,     "lock_idle");
        push(62, 1, 0, 0, FAN_LEAD, "rereq_fan");
        run_to(0);
        ac_req = 1'b1;
        run_to(6);
        ac_req = 1'b0;
        run_to(34);
        ac_req = 1'b1;
        run_to(63);
        drain_check("minon");

        // Fault trip during RUN
        reset_dut();
        push(9,  1, 1, 0, RUN,     "fault_pre");
        push(10, 0, 0, 1, FAULT,   "fault_trip");
        push(15, 0, 0, 1, FAULT,   "fault_hold");
        push(16, 0, 0, 1, LOCKOUT, "fault_lock");
        push(47, 0, 0, 1, LOCKOUT, "fault_lock_end");
        push(48, 0, 0, 0, IDLE,    "fault_idle");
        run_to(0);
        ac_req = 1'b1;
        run_to(9);
        fault = 1'b1;
        run_to(15);
        fault  = 1'b0;
        ac_req = 1'b0;
        run_to(49);
        drain_check("fault");

        // Reset in the middle of RUN
        reset_dut();
        push(7,  1, 1, 0, RUN,      "rst_pre");
        push(8,  0, 0, 0, IDLE,     "rst_idle");
        push(9,  1, 0, 0, FAN_LEAD, "rst_restart");
        push(13, 1, 1, 0, RUN,      "rst_run");
        run_to(0);
        ac_req = 1'b1;
        run_to(7);
        reset = 1'b1;
        run_to(8);
        reset = 1'b0;
        run_to(13);
        drain_check("reset_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
